fft_stage_seq_ctrl: RTL and testbench

- Parameterized sequencer for one radix-2 FFT stage: delayed-sub shift register, 32-to-16 mux, second shift register, BF2I butterfly, twiddle multiplier.
- Started by a one-cycle alert from the upstream stage. Generates mux select, butterfly enable, multiplier enable and twiddle address, then issues the downstream alert.
- Supports back-to-back frames and reports overrun errors.
- Each instance is sized for its stage through parameters.

---
 rtl/fft_stage_seq_ctrl.sv | 104 ++++++++++
 tb/tb_fft_stage_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_seq_ctrl.sv
// Sequencer for one radix-2 FFT stage: turns an upstream alert into mux/butterfly/multiplier
// controls, a twiddle address stream and a downstream alert, with overrun and frame accounting.
module fft_stage_seq_ctrl #(
   parameter int FRAME_CYC = 32,
   parameter int SUB_DEPTH = 8,
   parameter int BF_DEPTH  = 4,
   parameter int BF_LAT    = 1,
   parameter int MUL_LAT   = 1,
   parameter int ADDR_W    = 9
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              alert_in,
   output logic              mux_sel,
   output logic              bf_en,
   output logic              mul_en,
   output logic [ADDR_W-1:0] addr,
   output logic              alert_out,
   output logic              busy,
   output logic              done,
   output logic              err_overrun,
   output logic [7:0]        frame_cnt
);

   localparam int RUN_CYC = FRAME_CYC + SUB_DEPTH;
   localparam int CNT_W   = $clog2(RUN_CYC);
   localparam int SUB_B   = $clog2(SUB_DEPTH);
   localparam int BF_B    = $clog2(BF_DEPTH);
   localparam int MK_LEN  = BF_LAT + MUL_LAT - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MARK = CNT_W'(BF_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               run_n;
   logic               drain_empty;
   // Bit 0 of each shift register is the butterfly-side stage; the top bit is the output stage.
   logic [BF_LAT:0]    en_sr;
   logic [BF_LAT:0]    last_sr;
   logic [MK_LEN:0]    mark_sr;

   // Empty next cycle: nothing left to shift into the final stages.
   assign drain_empty = ~|en_sr[BF_LAT-1:0] & ~|last_sr[BF_LAT-1:0] & ~|mark_sr[MK_LEN-1:0];
   assign run_n       = (state_n == RUN);

   assign bf_en     = en_sr[0];
   assign mul_en    = en_sr[BF_LAT];
   assign alert_out = mark_sr[MK_LEN];
   assign done      = last_sr[BF_LAT];

   always_comb begin
      state_n = state;
      cnt_n   = '0;
      case (state)
         IDLE: begin
            if (alert_in) state_n = RUN;
         end
         RUN: begin
            if (cnt == CNT_LAST) begin
               if (!alert_in) state_n = FLUSH;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         FLUSH: begin
            if (alert_in)         state_n = RUN;
            else if (drain_empty) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Decodes are registered from the next count so they line up with the cycle cnt holds it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         mux_sel     <= 1'b0;
         en_sr       <= '0;
         last_sr     <= '0;
         mark_sr     <= '0;
         addr        <= '0;
         frame_cnt   <= '0;
         err_overrun <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         busy    <= (state_n != IDLE);
         mux_sel <= run_n & cnt_n[SUB_B];
         en_sr   <= {en_sr[BF_LAT-1:0], run_n & cnt_n[BF_B]};
         mark_sr <= {mark_sr[MK_LEN-1:0], run_n && (cnt_n == CNT_MARK)};
         last_sr <= {last_sr[BF_LAT-1:0], run_n && (cnt_n == CNT_LAST) && cnt_n[BF_B]};
         // The marker restart wins over increment so a new frame cleanly overrides the old tail.
         if (mark_sr[BF_LAT-1])  addr <= '0;
         else if (en_sr[BF_LAT]) addr <= addr + ADDR_W'(1);
         if (last_sr[BF_LAT-1])  frame_cnt <= frame_cnt + 8'd1;
         if (state == RUN && alert_in && cnt != CNT_LAST) err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_stage_seq_ctrl.sv
// Directed bench for fft_stage_seq_ctrl: a default instance plus a BF_LAT=2/MUL_LAT=3 instance
// sharing the same alert/reset stimulus.
module tb_fft_stage_seq_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       alert_in = 1'b0;
   logic       mux_sel, bf_en, mul_en, alert_out, busy, done, err_overrun;
   logic [8:0] addr;
   logic [7:0] frame_cnt;
   logic       mux_sel2, bf_en2, mul_en2, alert_out2, busy2, done2, err_overrun2;
   logic [8:0] addr2;
   logic [7:0] frame_cnt2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int k;
      bit mux, bf, mul, al, dn, busy;
      int addr, fc;
      bit mul2, al2, dn2;
   } vec_t;

   vec_t vecs[15];

   fft_stage_seq_ctrl u_dut (
      .clk(clk), .rstn(rstn), .alert_in(alert_in), .mux_sel(mux_sel), .bf_en(bf_en),
      .mul_en(mul_en), .addr(addr), .alert_out(alert_out), .busy(busy), .done(done),
      .err_overrun(err_overrun), .frame_cnt(frame_cnt)
   );

   fft_stage_seq_ctrl #(.BF_LAT(2), .MUL_LAT(3)) u_dut2 (
      .clk(clk), .rstn(rstn), .alert_in(alert_in), .mux_sel(mux_sel2), .bf_en(bf_en2),
      .mul_en(mul_en2), .addr(addr2), .alert_out(alert_out2), .busy(busy2), .done(done2),
      .err_overrun(err_overrun2), .frame_cnt(frame_cnt2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp_v);
      end
   endtask

   task automatic apply_reset();
      alert_in = 1'b0;
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
      step();
   endtask

   // Alert in the current cycle T, then walk T+1..T+45 against the table.
   task automatic apply_stimulus(input int ovr_k);
      int n_al = 0, n_dn = 0, n_mul = 0, n_al2 = 0, n_dn2 = 0, n_mul2 = 0;
      alert_in = 1'b1;
      step();
      alert_in = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         alert_in = (k == ovr_k);
         n_al += int'(alert_out);  n_dn += int'(done);  n_mul += int'(mul_en);
         n_al2 += int'(alert_out2); n_dn2 += int'(done2); n_mul2 += int'(mul_en2);
         for (int r = 0; r < 15; r++) begin
            if (vecs[r].k == k) begin
               check_output("mux_sel", mux_sel, vecs[r].mux);
               check_output("bf_en", bf_en, vecs[r].bf);
               check_output("mul_en", mul_en, vecs[r].mul);
               check_output("alert_out", alert_out, vecs[r].al);
               check_output("done", done, vecs[r].dn);
               check_output("busy", busy, vecs[r].busy);
               check_output("addr", addr, vecs[r].addr);
               check_output("frame_cnt", frame_cnt, vecs[r].fc);
               check_output("mul_en2", mul_en2, vecs[r].mul2);
               check_output("alert_out2", alert_out2, vecs[r].al2);
               check_output("done2", done2, vecs[r].dn2);
               check_output("err_overrun", err_overrun, (ovr_k > 0 && k > ovr_k));
            end
         end
         step();
      end
      alert_in = 1'b0;
      check_output("alert_out pulses", n_al, 1);
      check_output("done pulses", n_dn, 1);
      check_output("mul_en cycles", n_mul, 20);
      check_output("alert_out2 pulses", n_al2, 1);
      check_output("done2 pulses", n_dn2, 1);
      check_output("mul_en2 cycles", n_mul2, 20);
   endtask

   initial begin
      int n_al, n_dn, n_mul, j;

      //            k  mux bf mul al dn busy addr fc mul2 al2 dn2
      vecs[0]  = '{ 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
      vecs[1]  = '{ 5, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0};
      vecs[2]  = '{ 6, 0, 1, 1, 1, 0, 1,  0, 0, 0, 0, 0};
      vecs[3]  = '{ 7, 0, 1, 1, 0, 0, 1,  1, 0, 1, 0, 0};
      vecs[4]  = '{ 8, 0, 1, 1, 0, 0, 1,  2, 0, 1, 0, 0};
      vecs[5]  = '{ 9, 1, 0, 1, 0, 0, 1,  3, 0, 1, 1, 0};
      vecs[6]  = '{10, 1, 0, 0, 0, 0, 1,  4, 0, 1, 0, 0};
      vecs[7]  = '{11, 1, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0};
      vecs[8]  = '{14, 1, 1, 1, 0, 0, 1,  4, 0, 0, 0, 0};
      vecs[9]  = '{17, 0, 0, 1, 0, 0, 1,  7, 0, 1, 0, 0};
      vecs[10] = '{25, 1, 0, 1, 0, 0, 1, 11, 0, 1, 0, 0};
      vecs[11] = '{40, 0, 1, 1, 0, 0, 1, 18, 0, 1, 0, 0};
      vecs[12] = '{41, 0, 0, 1, 0, 1, 1, 19, 1, 1, 0, 0};
      vecs[13] = '{42, 0, 0, 0, 0, 0, 0, 20, 1, 1, 0, 1};
      vecs[14] = '{43, 0, 0, 0, 0, 0, 0, 20, 1, 0, 0, 0};

      // Reset values
      apply_reset();
      check_output("reset mux_sel", mux_sel, 0);
      check_output("reset bf_en", bf_en, 0);
      check_output("reset mul_en", mul_en, 0);
      check_output("reset addr", addr, 0);
      check_output("reset busy", busy, 0);
      check_output("reset frame_cnt", frame_cnt, 0);
      check_output("reset err_overrun", err_overrun, 0);

      $display("[TB] single frame");
      apply_stimulus(0);
      check_output("err_overrun clean", err_overrun, 0);

      $display("[TB] overrun at cnt=10");
      apply_reset();
      apply_stimulus(11);
      step();
      check_output("err_overrun sticky", err_overrun, 1);
      apply_reset();
      check_output("err_overrun cleared", err_overrun, 0);

      $display("[TB] back-to-back frames");
      apply_reset();
      alert_in = 1'b1;
      step();
      n_al = 0; n_dn = 0; n_mul = 0;
      for (int k = 1; k <= 85; k++) begin
         alert_in = (k == 40);
         j = (k <= 40) ? k : k - 40;
         check_output("b2b mux_sel", mux_sel, (k <= 80) ? ((j - 1) / 8) % 2 : 0);
         check_output("b2b bf_en", bf_en, (k <= 80) ? int'(((j - 1) % 8) >= 4) : 0);
         n_al += int'(alert_out); n_dn += int'(done); n_mul += int'(mul_en);
         if (k == 41) begin
            check_output("b2b old done", done, 1);
            check_output("b2b old last addr", addr, 19);
            check_output("b2b frame_cnt 1", frame_cnt, 1);
         end
         if (k == 46) begin
            check_output("b2b new alert_out", alert_out, 1);
            check_output("b2b new addr", addr, 0);
         end
         if (k == 81) begin
            check_output("b2b second done", done, 1);
            check_output("b2b frame_cnt 2", frame_cnt, 2);
         end
         if (k == 82) check_output("b2b idle", busy, 0);
         step();
      end
      alert_in = 1'b0;
      check_output("b2b alert pulses", n_al, 2);
      check_output("b2b done pulses", n_dn, 2);
      check_output("b2b mul_en cycles", n_mul, 40);

      $display("[TB] alert during flush");
      apply_reset();
      alert_in = 1'b1;
      step();
      n_al = 0; n_dn = 0;
      for (int k = 1; k <= 90; k++) begin
         alert_in = (k == 41);
         n_al += int'(alert_out); n_dn += int'(done);
         if (k == 41) begin
            check_output("flush done", done, 1);
            check_output("flush busy", busy, 1);
         end
         if (k == 42) begin
            check_output("restart busy", busy, 1);
            check_output("restart bf_en", bf_en, 0);
            check_output("restart done low", done, 0);
         end
         if (k == 46) check_output("restart bf_en high", bf_en, 1);
         if (k == 47) begin
            check_output("restart alert_out", alert_out, 1);
            check_output("restart addr", addr, 0);
         end
         if (k == 82) begin
            check_output("restart done", done, 1);
            check_output("restart frame_cnt", frame_cnt, 2);
         end
         if (k == 83) check_output("restart idle", busy, 0);
         step();
      end
      alert_in = 1'b0;
      check_output("flush alert pulses", n_al, 2);
      check_output("flush done pulses", n_dn, 2);

      $display("[TB] reset mid-frame");
      apply_reset();
      alert_in = 1'b1;
      step();
      alert_in = 1'b0;
      for (int k = 1; k <= 20; k++) step();
      #2;
      rstn = 1'b0;
      #1;
      check_output("async busy", busy, 0);
      check_output("async addr", addr, 0);
      check_output("async mux_sel", mux_sel, 0);
      check_output("async bf_en", bf_en, 0);
      check_output("async mul_en", mul_en, 0);
      check_output("async mul_en2", mul_en2, 0);
      step();
      step();
      rstn = 1'b1;
      n_al = 0; n_dn = 0; n_mul = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         n_al += int'(alert_out | alert_out2);
         n_dn += int'(done | done2);
         n_mul += int'(mul_en | mul_en2);
      end
      check_output("post-reset alert pulses", n_al, 0);
      check_output("post-reset done pulses", n_dn, 0);
      check_output("post-reset mul_en cycles", n_mul, 0);
      apply_stimulus(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
